// File: rtl/display_defs_pkg.sv
// display_defs: message-address codes and sequencer state encoding shared with the message memory
package display_defs;
  localparam logic [1:0] ADDR_NIVEL   = 2'b00;
  localparam logic [1:0] ADDR_VENCEU  = 2'b01;
  localparam logic [1:0] ADDR_PERDEU  = 2'b10;
  localparam logic [1:0] ADDR_APAGADO = 2'b11;
  typedef enum logic [2:0] {OCIOSO, NIVEL, RES_ON, RES_OFF, HOLD} state_t;
endpackage

// File: rtl/display_seq_ctrl_blink_timer.sv
// blink_timer: blink-phase counter with a terminal-count pulse on the last cycle of each phase
module blink_timer #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int CNT_W        = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  assign tc = en && cnt == CNT_W'(BLINK_CYCLES - 1);
  // count 0..BLINK_CYCLES-1 while enabled; clear wins over counting
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/display_seq_ctrl.sv
// display_seq_ctrl: picks message address and level code for the HEX message memory from game events
module display_seq_ctrl
  import display_defs::*;
#(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int NUM_BLINKS   = 3,
  parameter int CNT_W        = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] nivel,
  input  logic       venceu,
  input  logic       perdeu,
  output logic [1:0] displayAddr,
  output logic [1:0] modo,
  output logic       exibindo_resultado,
  output logic       fim_exibicao
);
  localparam logic [2:0] LAST = 3'(NUM_BLINKS);
  state_t     state;
  logic [1:0] res;
  logic [2:0] blinks;
  logic       en, clr, tc;
  assign en  = state == RES_ON || state == RES_OFF;
  assign clr = !en || iniciar;
  blink_timer #(.BLINK_CYCLES(BLINK_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr  (clr),
    .en   (en),
    .tc   (tc)
  );
  // sequencer FSM with registered outputs; iniciar outside NIVEL always (re)starts play
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state              <= OCIOSO;
      displayAddr        <= ADDR_APAGADO;
      modo               <= 2'b00;
      res                <= ADDR_APAGADO;
      blinks             <= 3'd0;
      exibindo_resultado <= 1'b0;
      fim_exibicao       <= 1'b0;
    end else begin
      fim_exibicao <= 1'b0;
      if (iniciar && state != NIVEL) begin
        state              <= NIVEL;
        displayAddr        <= ADDR_NIVEL;
        modo               <= nivel;
        blinks             <= 3'd0;
        exibindo_resultado <= 1'b0;
      end else
        case (state)
          NIVEL: begin
            modo <= nivel;
            if (venceu || perdeu) begin
              state              <= RES_ON;
              res                <= perdeu ? ADDR_PERDEU : ADDR_VENCEU;
              displayAddr        <= perdeu ? ADDR_PERDEU : ADDR_VENCEU;
              blinks             <= 3'd0;
              exibindo_resultado <= 1'b1;
            end
          end
          RES_ON:
            if (tc) begin
              state       <= RES_OFF;
              displayAddr <= ADDR_APAGADO;
              blinks      <= blinks + 3'd1;
            end
          RES_OFF:
            if (tc) begin
              displayAddr  <= res;
              state        <= blinks == LAST ? HOLD : RES_ON;
              fim_exibicao <= blinks == LAST;
            end
          default: ;
        endcase
    end
endmodule
